kv_stream_router: RTL and testbench

Parametrised N-input packet router for the card-side key/value stack. It sits between NUM_CH ingress AXI-Stream sources (adapter, host, and internal responders) and two egress streams: card→peer (adapter) and card→host. Each packet is steered by its tuser_dst field, sampled on the first beat. Each egress port runs an independent packet-locked round-robin arbiter, so both outputs can stream concurrently.

---
 rtl/kv_stream_router.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_kv_stream_router.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kv_stream_router.sv
// kv_stream_router: NUM_CH-input AXI-Stream router with independent packet-locked
// round-robin arbiters for the peer and host egress. Optional macro KV_ROUTER_LEN_CHECK_EN.

module kv_stream_router_egress #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W/8
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef KV_ROUTER_LEN_CHECK_EN
  output logic                     len_err,
`endif
  input  logic [NUM_CH-1:0]        cand,
  input  logic [NUM_CH-1:0]        head,
  input  logic [NUM_CH-1:0]        s_tvalid,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH*KEEP_W-1:0] s_tkeep,
  input  logic [NUM_CH-1:0]        s_tlast,
  input  logic [NUM_CH*16-1:0]     s_tuser_size,
  input  logic [NUM_CH*16-1:0]     s_tuser_src,
  input  logic [NUM_CH*16-1:0]     s_tuser_dst,
  output logic [NUM_CH-1:0]        s_tready,
  output logic                     m_tvalid,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [KEEP_W-1:0]        m_tkeep,
  output logic                     m_tlast,
  output logic [15:0]              m_tuser_size,
  output logic [15:0]              m_tuser_src,
  output logic [15:0]              m_tuser_dst,
  input  logic                     m_tready
);
  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_found;
  int                idx;
  logic [31:0]       g;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic              sel_last;
  logic [15:0]       sel_size;
  logic [15:0]       sel_src;
  logic [15:0]       sel_dst;
  logic              room;
  logic              accept;

  assign g        = 32'(grant);
  assign sel_data = s_tdata[g*DATA_W +: DATA_W];
  assign sel_keep = s_tkeep[g*KEEP_W +: KEEP_W];
  assign sel_last = s_tlast[grant];
  assign sel_size = s_tuser_size[g*16 +: 16];
  assign sel_src  = s_tuser_src[g*16 +: 16];
  assign sel_dst  = s_tuser_dst[g*16 +: 16];
  assign room     = !m_tvalid || m_tready;
  assign accept   = (state == LOCK) && s_tvalid[grant] && room;

  // First candidate at or after rr_ptr, searching cyclically.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!pick_found && cand[idx]) begin
        pick_found = 1'b1;
        pick_idx   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    s_tready = '0;
    if (state == LOCK) s_tready[grant] = room;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state        <= IDLE;
      grant        <= '0;
      rr_ptr       <= '0;
      m_tvalid     <= 1'b0;
      // NOTE: the payload registers are cleared as well so a reset mid-packet never
      // exposes a stale partial beat; they are plain flops, not a memory array.
      m_tdata      <= '0;
      m_tkeep      <= '0;
      m_tlast      <= 1'b0;
      m_tuser_size <= '0;
      m_tuser_src  <= '0;
      m_tuser_dst  <= '0;
    end else begin
      if (accept) begin
        m_tvalid <= 1'b1;
        m_tdata  <= sel_data;
        m_tkeep  <= sel_keep;
        m_tlast  <= sel_last;
        if (head[grant]) begin
          m_tuser_size <= sel_size;
          m_tuser_src  <= sel_src;
          m_tuser_dst  <= sel_dst;
        end
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      case (state)
        IDLE: if (pick_found) begin
          grant <= pick_idx;
          state <= LOCK;
        end
        LOCK: if (accept && sel_last) begin
          state  <= IDLE;
          rr_ptr <= (grant == CH_W'(NUM_CH-1)) ? '0 : grant + CH_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KV_ROUTER_LEN_CHECK_EN
  function automatic logic [15:0] popcount(input logic [KEEP_W-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < KEEP_W; i++) n = n + 16'(v[i]);
    return n;
  endfunction

  logic [15:0] acc;
  logic [15:0] total;
  logic [15:0] size_ref;

  // On a single-beat packet the size is still on the input, not yet in m_tuser_size.
  assign total    = acc + popcount(sel_keep);
  assign size_ref = head[grant] ? sel_size : m_tuser_size;
  assign len_err  = accept && sel_last && (total != size_ref);

  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else if (accept) acc <= sel_last ? '0 : total;
  end
`endif

endmodule

module kv_stream_router #(
  parameter int          NUM_CH  = 4,
  parameter int          DATA_W  = 512,
  parameter int          KEEP_W  = DATA_W/8,
  parameter logic [15:0] HOST_ID = 16'h0000
) (
  input  logic                     axis_clk,
  input  logic                     axis_rst,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH*KEEP_W-1:0] s_axis_tkeep,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  input  logic [NUM_CH*16-1:0]     s_axis_tuser_size,
  input  logic [NUM_CH*16-1:0]     s_axis_tuser_src,
  input  logic [NUM_CH*16-1:0]     s_axis_tuser_dst,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic                     m_axis_peer_tvalid,
  output logic [DATA_W-1:0]        m_axis_peer_tdata,
  output logic [KEEP_W-1:0]        m_axis_peer_tkeep,
  output logic                     m_axis_peer_tlast,
  output logic [15:0]              m_axis_peer_tuser_size,
  output logic [15:0]              m_axis_peer_tuser_src,
  output logic [15:0]              m_axis_peer_tuser_dst,
  input  logic                     m_axis_peer_tready,
  output logic                     m_axis_host_tvalid,
  output logic [DATA_W-1:0]        m_axis_host_tdata,
  output logic [KEEP_W-1:0]        m_axis_host_tkeep,
  output logic                     m_axis_host_tlast,
  output logic [15:0]              m_axis_host_tuser_size,
  output logic [15:0]              m_axis_host_tuser_src,
  output logic [15:0]              m_axis_host_tuser_dst,
  input  logic                     m_axis_host_tready,
  output logic                     err_len,
  output logic [15:0]              err_len_cnt
);
  logic [NUM_CH-1:0] head;
  logic [NUM_CH-1:0] route;
  logic [NUM_CH-1:0] cand_peer;
  logic [NUM_CH-1:0] cand_host;
  logic [NUM_CH-1:0] rdy_peer;
  logic [NUM_CH-1:0] rdy_host;

  always_comb begin
    route = '0;
    for (int i = 0; i < NUM_CH; i++) route[i] = (s_axis_tuser_dst[i*16 +: 16] == HOST_ID);
  end

  // A head channel is offered to exactly one arbiter, so the two grants never collide.
  assign cand_host     = s_axis_tvalid & head & route;
  assign cand_peer     = s_axis_tvalid & head & ~route;
  assign s_axis_tready = rdy_peer | rdy_host;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      head <= '1;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (s_axis_tvalid[i] && s_axis_tready[i]) head[i] <= s_axis_tlast[i];
    end
  end

`ifdef KV_ROUTER_LEN_CHECK_EN
  logic        err_peer;
  logic        err_host;
  logic [16:0] cnt_sum;

  assign cnt_sum = {1'b0, err_len_cnt} + 17'(err_peer) + 17'(err_host);

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      err_len     <= 1'b0;
      err_len_cnt <= '0;
    end else begin
      err_len     <= err_peer | err_host;
      err_len_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
`else
  assign err_len     = 1'b0;
  assign err_len_cnt = '0;
`endif

  kv_stream_router_egress #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .KEEP_W(KEEP_W)) u_peer (
    .clk          (axis_clk),
    .rst          (axis_rst),
`ifdef KV_ROUTER_LEN_CHECK_EN
    .len_err      (err_peer),
`endif
    .cand         (cand_peer),
    .head         (head),
    .s_tvalid     (s_axis_tvalid),
    .s_tdata      (s_axis_tdata),
    .s_tkeep      (s_axis_tkeep),
    .s_tlast      (s_axis_tlast),
    .s_tuser_size (s_axis_tuser_size),
    .s_tuser_src  (s_axis_tuser_src),
    .s_tuser_dst  (s_axis_tuser_dst),
    .s_tready     (rdy_peer),
    .m_tvalid     (m_axis_peer_tvalid),
    .m_tdata      (m_axis_peer_tdata),
    .m_tkeep      (m_axis_peer_tkeep),
    .m_tlast      (m_axis_peer_tlast),
    .m_tuser_size (m_axis_peer_tuser_size),
    .m_tuser_src  (m_axis_peer_tuser_src),
    .m_tuser_dst  (m_axis_peer_tuser_dst),
    .m_tready     (m_axis_peer_tready)
  );

  kv_stream_router_egress #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .KEEP_W(KEEP_W)) u_host (
    .clk          (axis_clk),
    .rst          (axis_rst),
`ifdef KV_ROUTER_LEN_CHECK_EN
    .len_err      (err_host),
`endif
    .cand         (cand_host),
    .head         (head),
    .s_tvalid     (s_axis_tvalid),
    .s_tdata      (s_axis_tdata),
    .s_tkeep      (s_axis_tkeep),
    .s_tlast      (s_axis_tlast),
    .s_tuser_size (s_axis_tuser_size),
    .s_tuser_src  (s_axis_tuser_src),
    .s_tuser_dst  (s_axis_tuser_dst),
    .s_tready     (rdy_host),
    .m_tvalid     (m_axis_host_tvalid),
    .m_tdata      (m_axis_host_tdata),
    .m_tkeep      (m_axis_host_tkeep),
    .m_tlast      (m_axis_host_tlast),
    .m_tuser_size (m_axis_host_tuser_size),
    .m_tuser_src  (m_axis_host_tuser_src),
    .m_tuser_dst  (m_axis_host_tuser_dst),
    .m_tready     (m_axis_host_tready)
  );

endmodule

// File: tb/tb_kv_stream_router.sv
// Self-checking bench for kv_stream_router: table-driven single-packet routing vectors
// plus directed round-robin, concurrency, backpressure, length-check and reset sequences.

module tb_kv_stream_router;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;

  logic                     axis_clk;
  logic                     axis_rst;
  logic [NUM_CH-1:0]        s_axis_tvalid;
  logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
  logic [NUM_CH*KEEP_W-1:0] s_axis_tkeep;
  logic [NUM_CH-1:0]        s_axis_tlast;
  logic [NUM_CH*16-1:0]     s_axis_tuser_size;
  logic [NUM_CH*16-1:0]     s_axis_tuser_src;
  logic [NUM_CH*16-1:0]     s_axis_tuser_dst;
  logic [NUM_CH-1:0]        s_axis_tready;
  logic                     m_axis_peer_tvalid;
  logic [DATA_W-1:0]        m_axis_peer_tdata;
  logic [KEEP_W-1:0]        m_axis_peer_tkeep;
  logic                     m_axis_peer_tlast;
  logic [15:0]              m_axis_peer_tuser_size;
  logic [15:0]              m_axis_peer_tuser_src;
  logic [15:0]              m_axis_peer_tuser_dst;
  logic                     m_axis_peer_tready;
  logic                     m_axis_host_tvalid;
  logic [DATA_W-1:0]        m_axis_host_tdata;
  logic [KEEP_W-1:0]        m_axis_host_tkeep;
  logic                     m_axis_host_tlast;
  logic [15:0]              m_axis_host_tuser_size;
  logic [15:0]              m_axis_host_tuser_src;
  logic [15:0]              m_axis_host_tuser_dst;
  logic                     m_axis_host_tready;
  logic                     err_len;
  logic [15:0]              err_len_cnt;

  kv_stream_router #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .KEEP_W(KEEP_W), .HOST_ID(16'h0000)
  ) dut (
    .axis_clk               (axis_clk),
    .axis_rst               (axis_rst),
    .s_axis_tvalid          (s_axis_tvalid),
    .s_axis_tdata           (s_axis_tdata),
    .s_axis_tkeep           (s_axis_tkeep),
    .s_axis_tlast           (s_axis_tlast),
    .s_axis_tuser_size      (s_axis_tuser_size),
    .s_axis_tuser_src       (s_axis_tuser_src),
    .s_axis_tuser_dst       (s_axis_tuser_dst),
    .s_axis_tready          (s_axis_tready),
    .m_axis_peer_tvalid     (m_axis_peer_tvalid),
    .m_axis_peer_tdata      (m_axis_peer_tdata),
    .m_axis_peer_tkeep      (m_axis_peer_tkeep),
    .m_axis_peer_tlast      (m_axis_peer_tlast),
    .m_axis_peer_tuser_size (m_axis_peer_tuser_size),
    .m_axis_peer_tuser_src  (m_axis_peer_tuser_src),
    .m_axis_peer_tuser_dst  (m_axis_peer_tuser_dst),
    .m_axis_peer_tready     (m_axis_peer_tready),
    .m_axis_host_tvalid     (m_axis_host_tvalid),
    .m_axis_host_tdata      (m_axis_host_tdata),
    .m_axis_host_tkeep      (m_axis_host_tkeep),
    .m_axis_host_tlast      (m_axis_host_tlast),
    .m_axis_host_tuser_size (m_axis_host_tuser_size),
    .m_axis_host_tuser_src  (m_axis_host_tuser_src),
    .m_axis_host_tuser_dst  (m_axis_host_tuser_dst),
    .m_axis_host_tready     (m_axis_host_tready),
    .err_len                (err_len),
    .err_len_cnt            (err_len_cnt)
  );

  initial begin
    axis_clk = 1'b0;
    forever #5 axis_clk = ~axis_clk;
  end

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [15:0]       size;
    logic [15:0]       src;
    logic [15:0]       dst;
    int                cyc;
  } beat_t;

  typedef struct {
    int          ch;
    logic [15:0] dst;
    int          nbeats;
    logic [15:0] size;
    bit          exp_host;
  } vec_t;

  beat_t src_q[NUM_CH][$];
  beat_t peer_rx[$];
  beat_t host_rx[$];
  int    accepted[NUM_CH];
  bit [NUM_CH-1:0] acc;
  int    cyc;
  int    err_pulses;
  int    errors;
  int    checks;

  logic              snap_peer_valid, snap_host_valid, snap_peer_last, snap_err;
  logic [DATA_W-1:0] snap_peer_data, snap_host_data;
  logic [47:0]       snap_peer_user, snap_host_user;
  logic [NUM_CH-1:0] snap_tready;
  logic [15:0]       snap_cnt;

  function automatic logic [DATA_W-1:0] mkdata(input int ch, input int b);
    return {16{8'(ch), 8'(b), 16'hC0DE}};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_now();
    beat_t b;
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_q[c].size() > 0) begin
        b = src_q[c][0];
        s_axis_tvalid[c] = 1'b1;
        s_axis_tdata[c*DATA_W +: DATA_W]  = b.data;
        s_axis_tkeep[c*KEEP_W +: KEEP_W]  = b.keep;
        s_axis_tlast[c] = b.last;
        s_axis_tuser_size[c*16 +: 16] = b.size;
        s_axis_tuser_src[c*16 +: 16]  = b.src;
        s_axis_tuser_dst[c*16 +: 16]  = b.dst;
      end else begin
        s_axis_tvalid[c] = 1'b0;
        s_axis_tdata[c*DATA_W +: DATA_W] = '0;
        s_axis_tkeep[c*KEEP_W +: KEEP_W] = '0;
        s_axis_tlast[c] = 1'b0;
        s_axis_tuser_size[c*16 +: 16] = '0;
        s_axis_tuser_src[c*16 +: 16]  = '0;
        s_axis_tuser_dst[c*16 +: 16]  = '0;
      end
    end
  endtask

  // One clock: sample at the falling edge, then advance the sources just after the rising edge.
  task automatic tick();
    beat_t b;
    @(negedge axis_clk);
    for (int c = 0; c < NUM_CH; c++) acc[c] = s_axis_tvalid[c] & s_axis_tready[c];
    if (m_axis_peer_tvalid && m_axis_peer_tready) begin
      b.data = m_axis_peer_tdata; b.keep = m_axis_peer_tkeep; b.last = m_axis_peer_tlast;
      b.size = m_axis_peer_tuser_size; b.src = m_axis_peer_tuser_src;
      b.dst = m_axis_peer_tuser_dst; b.cyc = cyc;
      peer_rx.push_back(b);
    end
    if (m_axis_host_tvalid && m_axis_host_tready) begin
      b.data = m_axis_host_tdata; b.keep = m_axis_host_tkeep; b.last = m_axis_host_tlast;
      b.size = m_axis_host_tuser_size; b.src = m_axis_host_tuser_src;
      b.dst = m_axis_host_tuser_dst; b.cyc = cyc;
      host_rx.push_back(b);
    end
    if (err_len === 1'b1) err_pulses++;
    snap_peer_valid = m_axis_peer_tvalid;
    snap_host_valid = m_axis_host_tvalid;
    snap_peer_last  = m_axis_peer_tlast;
    snap_peer_data  = m_axis_peer_tdata;
    snap_host_data  = m_axis_host_tdata;
    snap_peer_user  = {m_axis_peer_tuser_size, m_axis_peer_tuser_src, m_axis_peer_tuser_dst};
    snap_host_user  = {m_axis_host_tuser_size, m_axis_host_tuser_src, m_axis_host_tuser_dst};
    snap_tready     = s_axis_tready;
    snap_err        = err_len;
    snap_cnt        = err_len_cnt;
    @(posedge axis_clk);
    cyc++;
    #1;
    for (int c = 0; c < NUM_CH; c++)
      if (acc[c]) begin
        accepted[c]++;
        if (src_q[c].size() > 0) void'(src_q[c].pop_front());
      end
    drive_now();
  endtask

  task automatic clear_all();
    for (int c = 0; c < NUM_CH; c++) begin
      src_q[c].delete();
      accepted[c] = 0;
    end
    peer_rx.delete();
    host_rx.delete();
    err_pulses = 0;
  endtask

  task automatic push_pkt(input int ch, input logic [15:0] dst, input int nbeats,
                          input logic [15:0] size, input logic [KEEP_W-1:0] last_keep);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = mkdata(ch, i);
      b.keep = (i == nbeats-1) ? last_keep : '1;
      b.last = (i == nbeats-1);
      b.size = size;
      b.src  = 16'(16'h10 + ch);
      b.dst  = dst;
      b.cyc  = 0;
      src_q[ch].push_back(b);
    end
  endtask

  // Compares one received packet starting at first_idx; exp_cyc < 0 skips the timing check.
  task automatic check_pkt(input string name, input bit host, input int ch, input int nbeats,
                           input int first_idx, input int exp_cyc, input logic [15:0] size,
                           input logic [15:0] dst);
    bit    ok_data;
    bit    ok_time;
    int    n;
    beat_t b;
    ok_data = 1'b1;
    ok_time = 1'b1;
    n = host ? host_rx.size() : peer_rx.size();
    for (int i = 0; i < nbeats; i++) begin
      if (first_idx + i >= n) begin
        ok_data = 1'b0;
        ok_time = 1'b0;
      end else begin
        b = host ? host_rx[first_idx+i] : peer_rx[first_idx+i];
        if (b.data !== mkdata(ch, i) || b.keep !== '1 || b.last !== (i == nbeats-1) ||
            b.size !== size || b.src !== 16'(16'h10 + ch) || b.dst !== dst)
          ok_data = 1'b0;
        if (b.cyc != exp_cyc + i) ok_time = 1'b0;
      end
    end
    check({name, " content"}, 64'(ok_data), 64'd1);
    if (exp_cyc >= 0) check({name, " timing"}, 64'(ok_time), 64'd1);
  endtask

  task automatic do_reset();
    axis_rst = 1'b1;
    clear_all();
    drive_now();
    repeat (3) tick();
    axis_rst = 1'b0;
  endtask

  vec_t vecs[5];
  int   start;
  int   got_src;

  initial begin
    vecs[0] = '{0, 16'h0000, 3, 16'd192, 1'b1};
    vecs[1] = '{1, 16'h0005, 1, 16'd64,  1'b0};
    vecs[2] = '{2, 16'h0000, 2, 16'd128, 1'b1};
    vecs[3] = '{3, 16'hFFFF, 4, 16'd256, 1'b0};
    vecs[4] = '{1, 16'h0000, 1, 16'd64,  1'b1};

    errors = 0;
    checks = 0;
    cyc = 0;
    axis_rst = 1'b1;
    m_axis_peer_tready = 1'b1;
    m_axis_host_tready = 1'b1;
    s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = '0;
    s_axis_tuser_size = '0; s_axis_tuser_src = '0; s_axis_tuser_dst = '0;

    do_reset();
    check("reset peer tvalid", 64'(snap_peer_valid), 64'd0);
    check("reset host tvalid", 64'(snap_host_valid), 64'd0);
    check("reset peer tdata zero", 64'(snap_peer_data == '0), 64'd1);
    check("reset host tuser", snap_host_user, 64'd0);
    check("reset s_tready", 64'(snap_tready), 64'd0);
    check("reset err_len", 64'(snap_err), 64'd0);
    check("reset err_len_cnt", 64'(snap_cnt), 64'd0);

    // Single packets routed one at a time.
    for (int v = 0; v < 5; v++) begin
      clear_all();
      push_pkt(vecs[v].ch, vecs[v].dst, vecs[v].nbeats, vecs[v].size, '1);
      start = cyc;
      drive_now();
      repeat (vecs[v].nbeats + 6) tick();
      check($sformatf("vec%0d host beats", v), 64'(host_rx.size()),
            vecs[v].exp_host ? 64'(vecs[v].nbeats) : 64'd0);
      check($sformatf("vec%0d peer beats", v), 64'(peer_rx.size()),
            vecs[v].exp_host ? 64'd0 : 64'(vecs[v].nbeats));
      check_pkt($sformatf("vec%0d", v), vecs[v].exp_host, vecs[v].ch, vecs[v].nbeats, 0,
                start + 2, vecs[v].size, vecs[v].dst);
      check($sformatf("vec%0d err pulses", v), 64'(err_pulses), 64'd0);
    end

    // Round robin: four simultaneous 2-beat peer packets, one idle cycle between packets.
    do_reset();
    for (int c = 0; c < NUM_CH; c++) push_pkt(c, 16'(16'h0100 + c), 2, 16'd128, '1);
    start = cyc;
    drive_now();
    repeat (16) tick();
    check("rr peer beats", 64'(peer_rx.size()), 64'd8);
    check("rr host beats", 64'(host_rx.size()), 64'd0);
    for (int p = 0; p < NUM_CH; p++)
      check_pkt($sformatf("rr pkt%0d", p), 1'b0, p, 2, 2*p, start + 2 + 3*p, 16'd128,
                16'(16'h0100 + p));
    // Pointer wrapped back to 0: ch1 must beat ch3.
    clear_all();
    push_pkt(3, 16'h0103, 2, 16'd128, '1);
    push_pkt(1, 16'h0101, 2, 16'd128, '1);
    start = cyc;
    drive_now();
    repeat (10) tick();
    got_src = (peer_rx.size() > 0) ? int'(peer_rx[0].src) : -1;
    check("rr wrap first src", 64'(got_src), 64'h11);
    check_pkt("rr wrap ch1", 1'b0, 1, 2, 0, start + 2, 16'd128, 16'h0101);
    check_pkt("rr wrap ch3", 1'b0, 3, 2, 2, start + 5, 16'd128, 16'h0103);

    // Concurrency: both egresses stream on the same cycles.
    clear_all();
    push_pkt(1, 16'h0000, 4, 16'd256, '1);
    push_pkt(2, 16'h0007, 4, 16'd256, '1);
    start = cyc;
    drive_now();
    repeat (10) tick();
    check("conc host beats", 64'(host_rx.size()), 64'd4);
    check("conc peer beats", 64'(peer_rx.size()), 64'd4);
    check_pkt("conc host", 1'b1, 1, 4, 0, start + 2, 16'd256, 16'h0000);
    check_pkt("conc peer", 1'b0, 2, 4, 0, start + 2, 16'd256, 16'h0007);

    // Backpressure: host tready 1,0,0,1 while beats 0..1 are on the egress.
    clear_all();
    push_pkt(0, 16'h0000, 4, 16'd256, '1);
    start = cyc;
    drive_now();
    for (int off = 0; off < 12; off++) begin
      m_axis_host_tready = !(off == 3 || off == 4);
      tick();
      if (off == 3 || off == 4) begin
        check($sformatf("bp off%0d valid", off), 64'(snap_host_valid), 64'd1);
        check($sformatf("bp off%0d data held", off), 64'(snap_host_data == mkdata(0, 1)), 64'd1);
        check($sformatf("bp off%0d s_tready", off), 64'(snap_tready[0]), 64'd0);
      end
    end
    m_axis_host_tready = 1'b1;
    check("bp host beats", 64'(host_rx.size()), 64'd4);
    check_pkt("bp", 1'b1, 0, 4, 0, -1, 16'd256, 16'h0000);

    // Length check: 64 + 8 bytes against size 128, then against size 72.
    clear_all();
    push_pkt(2, 16'h0000, 2, 16'd128, 64'h00FF);
    drive_now();
    repeat (8) tick();
    check("len bad beats", 64'(host_rx.size()), 64'd2);
`ifdef KV_ROUTER_LEN_CHECK_EN
    check("len bad pulses", 64'(err_pulses), 64'd1);
    check("len bad cnt", 64'(err_len_cnt), 64'd1);
`else
    check("len bad pulses", 64'(err_pulses), 64'd0);
    check("len bad cnt", 64'(err_len_cnt), 64'd0);
`endif
    clear_all();
    push_pkt(2, 16'h0000, 2, 16'd72, 64'h00FF);
    drive_now();
    repeat (8) tick();
    check("len ok beats", 64'(host_rx.size()), 64'd2);
    check("len ok pulses", 64'(err_pulses), 64'd0);
`ifdef KV_ROUTER_LEN_CHECK_EN
    check("len ok cnt", 64'(err_len_cnt), 64'd1);
`else
    check("len ok cnt", 64'(err_len_cnt), 64'd0);
`endif

    // Reset mid-packet after two accepted beats of four.
    clear_all();
    push_pkt(3, 16'h0042, 4, 16'd256, '1);
    drive_now();
    for (int t = 0; t < 10 && accepted[3] < 2; t++) tick();
    check("mid rst beats before", 64'(accepted[3]), 64'd2);
    axis_rst = 1'b1;
    tick();
    clear_all();
    drive_now();
    axis_rst = 1'b0;
    tick();
    check("mid rst peer tvalid", 64'(snap_peer_valid), 64'd0);
    check("mid rst peer tdata zero", 64'(snap_peer_data == '0), 64'd1);
    check("mid rst peer tlast", 64'(snap_peer_last), 64'd0);
    check("mid rst peer tuser", snap_peer_user, 64'd0);
    check("mid rst s_tready", 64'(snap_tready), 64'd0);
    check("mid rst err_len_cnt", 64'(snap_cnt), 64'd0);
    // The next beat on ch3 is a fresh head and the arbiter starts from IDLE.
    clear_all();
    push_pkt(3, 16'h0042, 2, 16'd128, '1);
    start = cyc;
    drive_now();
    repeat (8) tick();
    check("post rst peer beats", 64'(peer_rx.size()), 64'd2);
    check_pkt("post rst", 1'b0, 3, 2, 0, start + 2, 16'd128, 16'h0042);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
